// File: rtl/gpio_in_capture_if.sv
// Bus interface for gpio_in_capture: CPU-side write data, address, strobe and registered read data.
interface gpio_in_capture_if #(
  parameter int unsigned NPINS = 16
);
  logic [NPINS-1:0] data_write;
  logic [NPINS-1:0] data_read;
  logic [1:0]       addr;
  logic             w_strobe;

  modport master (output data_write, output addr, output w_strobe, input data_read);
  modport slave  (input data_write, input addr, input w_strobe, output data_read);
endinterface

// File: rtl/gpio_in_capture.sv
// gpio_in_capture: synchronises input pins, filters the level, latches enabled edges as sticky events, raises irq.
// Optional per-pin debounce filter is built when GPIO_DEBOUNCE_EN is defined.
module gpio_in_capture #(
  parameter int unsigned npins     = 16,
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  gpio_in_capture_if.slave bus,
  input  logic [npins-1:0] pins_in,
  output logic             irq
);

  localparam int unsigned AW = 2;
  localparam logic [AW-1:0] A_LEVEL  = AW'(0);
  localparam logic [AW-1:0] A_RISE   = AW'(1);
  localparam logic [AW-1:0] A_FALL   = AW'(2);
  localparam logic [AW-1:0] A_STATUS = AW'(3);

  logic [npins-1:0] r_sync0;
  logic [npins-1:0] r_sync1;
  logic [npins-1:0] r_level;
  logic [npins-1:0] r_rise_en;
  logic [npins-1:0] r_fall_en;
  logic [npins-1:0] r_status;
  logic [npins-1:0] r_data_read;
  logic             r_irq;

  logic [npins-1:0] w_toggle;
  logic [npins-1:0] w_rise;
  logic [npins-1:0] w_fall;
  logic [npins-1:0] w_w1c;
  logic [npins-1:0] w_read;

`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [CW-1:0] r_cnt [npins];

  // Level flips on the DB_CYCLES-th consecutive cycle the synchronised pin disagrees with it
  always_comb begin
    w_toggle = '0;
    for (int unsigned i = 0; i < npins; i++) begin
      w_toggle[i] = (r_sync1[i] != r_level[i]) && (r_cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < npins; i++) begin
      if (!reset_n || (r_sync1[i] == r_level[i]) || w_toggle[i]) begin
        r_cnt[i] <= '0;
      end else begin
        r_cnt[i] <= r_cnt[i] + CW'(1);
      end
    end
  end
`else
  assign w_toggle = r_sync1 ^ r_level;
`endif

  assign w_rise = w_toggle &  r_sync1 & r_rise_en;
  assign w_fall = w_toggle & ~r_sync1 & r_fall_en;
  assign w_w1c  = (bus.w_strobe && (bus.addr == A_STATUS)) ? bus.data_write : '0;

  // Read mux; registered below so a same-cycle write returns the old value
  always_comb begin
    w_read = '0;
    case (bus.addr)
      A_LEVEL:  w_read = r_level;
      A_RISE:   w_read = r_rise_en;
      A_FALL:   w_read = r_fall_en;
      A_STATUS: w_read = r_status;
      default:  w_read = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync0     <= '0;
      r_sync1     <= '0;
      r_level     <= '0;
      r_rise_en   <= '0;
      r_fall_en   <= '0;
      r_status    <= '0;
      r_data_read <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_sync0 <= pins_in;
      r_sync1 <= r_sync0;
      r_level <= r_level ^ w_toggle;
      if (bus.w_strobe && (bus.addr == A_RISE)) r_rise_en <= bus.data_write;
      if (bus.w_strobe && (bus.addr == A_FALL)) r_fall_en <= bus.data_write;
      // New events override a simultaneous clear
      r_status    <= (r_status & ~w_w1c) | w_rise | w_fall;
      r_data_read <= w_read;
      r_irq       <= |r_status;
    end
  end

  assign bus.data_read = r_data_read;
  assign irq           = r_irq;

endmodule
